pc_unit_pl: RTL and testbench

PC_UNIT_PL -- requirements
Module: pc_unit_pl

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 71 +++++++
 rtl/pc_unit_pl.sv | 88 ++++++++
 tb/tb_pc_unit_pl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared types and constants for the program-counter unit.
// Rev     : 1.0  initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int IALIGN_HALF = 2;
    localparam int IALIGN_WORD = 4;

    // Number of low address bits that must be zero for an aligned target.
    function automatic int align_bits(input int ialign);
        return (ialign == IALIGN_WORD) ? 2 : 1;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_sel
// Purpose : Combinational next-PC / next-state selection with event priority.
// Rev     : 1.0  initial release
// ============================================================================
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
    parameter int              IALIGN      = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus_i,
    input  pc_state_e       state_i,
    input  logic            en_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_next_o,
    output pc_state_e       state_next_o,
    output logic            misalign_o,
    output logic            accept_o
);

    localparam int ABITS = align_bits(IALIGN);

    logic w_target_misaligned;
    assign w_target_misaligned = (redirect_target_i[ABITS-1:0] != '0);

    always_comb begin
        pc_next_o    = pc_i;
        state_next_o = state_i;
        misalign_o   = 1'b0;
        accept_o     = 1'b0;

        if (trap_valid_i) begin
            pc_next_o    = TRAP_VECTOR;
            state_next_o = ST_RUN;
            accept_o     = 1'b1;
        end else begin
            case (state_i)
                ST_RUN: begin
                    if (redirect_valid_i) begin
                        // A misaligned target is turned into a trap rather than fetched.
                        pc_next_o  = w_target_misaligned ? TRAP_VECTOR : redirect_target_i;
                        misalign_o = w_target_misaligned;
                        accept_o   = 1'b1;
                    end else if (halt_i) begin
                        state_next_o = ST_HALT;
                    end else if (en_i) begin
                        pc_next_o = pc_plus_i;
                    end
                end
                ST_HALT: begin
                    if (resume_i && !halt_i) begin
                        state_next_o = ST_RUN;
                    end
                end
                default: begin
                    state_next_o = ST_RUN;
                end
            endcase
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_unit_pl.sv
`default_nettype none
// ============================================================================
// Module  : pc_unit_pl
// Purpose : Program counter with BOOT/RUN/HALT control, traps and redirect count.
// Rev     : 1.0  initial release
// ============================================================================
module pc_unit_pl
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             halt,
    input  logic             resume,
    output logic [XLEN-1:0]  pc_current,
    output logic [XLEN-1:0]  pc_plus,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    pc_state_e        state_q;
    pc_state_e        state_d;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             pc_valid_q;
    logic             misalign_q;
    logic             misalign_d;
    logic             accept_d;
    logic [CNT_W-1:0] cnt_q;

    assign pc_plus = pc_q + XLEN'(IALIGN);

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_next_sel (
        .pc_i              (pc_q),
        .pc_plus_i         (pc_plus),
        .state_i           (state_q),
        .en_i              (en),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .trap_valid_i      (trap_valid),
        .halt_i            (halt),
        .resume_i          (resume),
        .pc_next_o         (pc_d),
        .state_next_o      (state_d),
        .misalign_o        (misalign_d),
        .accept_o          (accept_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= (state_d == ST_RUN);
            misalign_q <= misalign_d;
            // Counter holds at all-ones instead of wrapping.
            if (accept_d && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_current   = pc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule : pc_unit_pl
`default_nettype wire

// File: tb/tb_pc_unit_pl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_unit_pl
// Purpose : Self-checking bench for pc_unit_pl with a queue-based scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pc_unit_pl;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 2;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
    localparam logic [31:0] TVEC  = 32'h0000_0100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [XLEN-1:0]  redirect_target = '0;
    logic             trap_valid = 1'b0;
    logic             halt = 1'b0;
    logic             resume = 1'b0;
    logic [XLEN-1:0]  pc_current;
    logic [XLEN-1:0]  pc_plus;
    logic             pc_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0 = BOOT, 1 = RUN, 2 = HALT.
    logic [31:0] m_pc  = RVEC;
    int          m_st  = 0;
    logic        m_mis = 1'b0;
    logic [1:0]  m_cnt = 2'd0;

    pc_unit_pl #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RVEC),
        .TRAP_VECTOR  (TVEC),
        .IALIGN       (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt            (halt),
        .resume          (resume),
        .pc_current      (pc_current),
        .pc_plus         (pc_plus),
        .pc_valid        (pc_valid),
        .misalign_err    (misalign_err),
        .redirect_cnt    (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic bump_cnt();
        if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    endtask

    task automatic model_step();
        exp_t e;
        m_mis = 1'b0;
        if (rst) begin
            m_pc = RVEC; m_st = 0; m_cnt = 2'd0;
        end else if (trap_valid) begin
            m_pc = TVEC; m_st = 1; bump_cnt();
        end else if (m_st == 1 && redirect_valid) begin
            if (redirect_target % 4 != 0) begin
                m_pc = TVEC; m_mis = 1'b1;
            end else begin
                m_pc = redirect_target;
            end
            bump_cnt();
        end else if (m_st == 1 && halt) begin
            m_st = 2;
        end else if (m_st == 1 && en) begin
            m_pc = m_pc + 32'd4;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 2 && resume && !halt) begin
            m_st = 1;
        end
        e.pc = m_pc; e.valid = (m_st == 1); e.mis = m_mis; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict, clock, then compare the scoreboard entry.
    task automatic step(input logic i_rst, input logic i_en, input logic i_rv,
                        input logic [31:0] i_rt, input logic i_tv,
                        input logic i_h, input logic i_r);
        exp_t e;
        rst = i_rst; en = i_en; redirect_valid = i_rv; redirect_target = i_rt;
        trap_valid = i_tv; halt = i_h; resume = i_r;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc_current, e.pc);
            check("sb_pc_plus", pc_plus, e.pc + 32'd4);
            check("sb_valid", {31'd0, pc_valid}, {31'd0, e.valid});
            check("sb_mis", {31'd0, misalign_err}, {31'd0, e.mis});
            check("sb_cnt", {30'd0, redirect_cnt}, {30'd0, e.cnt});
        end
    endtask

    task automatic idle(input logic i_en);
        step(1'b0, i_en, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [31:0] tgt);
        step(1'b0, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        check("reset_pc", pc_current, 32'h0);
        check("reset_valid", {31'd0, pc_valid}, 32'd0);
        check("reset_cnt", {30'd0, redirect_cnt}, 32'd0);

        // Boot cycle then sequential fetch.
        idle(1'b1);
        check("boot_pc", pc_current, 32'h0);
        check("boot_valid", {31'd0, pc_valid}, 32'd1);
        idle(1'b1);
        check("seq_pc4", pc_current, 32'h4);
        idle(1'b1);
        check("seq_pc8", pc_current, 32'h8);

        // Redirect during a stall.
        redir(32'h20);
        redir(32'h80);
        check("redir_pc", pc_current, 32'h80);
        check("redir_cnt", {30'd0, redirect_cnt}, 32'd2);

        // Misaligned redirect becomes a trap.
        redir(32'h82);
        check("mis_pc", pc_current, 32'h100);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_cnt", {30'd0, redirect_cnt}, 32'd3);
        idle(1'b0);
        check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);

        // Trap beats redirect; redirect ignored during boot.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        check("boot_redir_ignored", pc_current, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        check("trap_over_redir", pc_current, 32'h100);

        // Halt, idle while halted, simultaneous halt+resume, then resume.
        redir(32'h40);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("halt_valid", {31'd0, pc_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, (i == 2), 32'h200, 1'b0, 1'b0, 1'b0);
            check("halt_hold_pc", pc_current, 32'h40);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("halt_resume_both", {31'd0, pc_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("resume_pc", pc_current, 32'h40);
        check("resume_valid", {31'd0, pc_valid}, 32'd1);
        idle(1'b1);
        check("resume_adv", pc_current, 32'h44);

        // Trap out of HALT.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("trap_from_halt", pc_current, 32'h100);

        // Address wrap and counter saturation.
        redir(32'hFFFF_FFFC);
        check("wrap_plus", pc_plus, 32'h0);
        idle(1'b1);
        check("wrap_pc", pc_current, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) redir(32'h10 * (i + 1));
        check("sat_cnt", {30'd0, redirect_cnt}, 32'd3);

        // Reset wins over a coincident trap while halted.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1);
        check("rst_override_pc", pc_current, 32'h0);
        check("rst_override_cnt", {30'd0, redirect_cnt}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 {24'd0, 8'($urandom_range(0, 255))},
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_unit_pl
`default_nettype wire
